// File: rtl/exe_wb_stage_pkg.sv
// exe_wb_stage_pkg: shared widths and the execute/writeback stage register layout
package exe_wb_stage_pkg;
  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              c;
    logic              z;
    logic [REG_AW-1:0] dst;
    logic              reg_we;
    logic              flags_we;
  } exwb_t;
endpackage

// File: rtl/exe_wb_stage_flag_reg.sv
// exe_wb_stage_flag_reg: architectural C/Z flags with commit enable and bypass
module exe_wb_stage_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic upd,
  input  logic c_in,
  input  logic z_in,
  output logic c_flag,
  output logic z_flag,
  output logic c_fwd,
  output logic z_fwd
);
  logic c_q, z_q;
  always_ff @(posedge clk) begin
    if (rst) {c_q, z_q} <= 2'b00;
    else if (en && upd) {c_q, z_q} <= {c_in, z_in};
  end
  assign c_flag = c_q;
  assign z_flag = z_q;
  assign c_fwd  = upd ? c_in : c_q;
  assign z_fwd  = upd ? z_in : z_q;
endmodule

// File: rtl/exe_wb_stage.sv
// exe_wb_stage: result select, writeback stage register, flag commit/bypass and retire counter
module exe_wb_stage
  import exe_wb_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              sel_shift,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic [DATA_W-1:0] shift_out,
  input  logic              shift_c,
  input  logic              shift_z,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic              reg_we,
  input  logic              flags_we,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              c_flag,
  output logic              z_flag,
  output logic              c_fwd,
  output logic              z_fwd,
  output logic [CNT_W-1:0]  retired
);
  exwb_t            stage_q, stage_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  always_comb begin
    stage_d = '{
      valid:    in_valid & ~flush,
      data:     sel_shift ? shift_out : alu_result,
      c:        sel_shift ? shift_c : alu_c,
      z:        sel_shift ? shift_z : alu_z,
      dst:      dst_reg,
      reg_we:   reg_we,
      flags_we: flags_we
    };
    retired_d = stage_q.valid ? retired_q + 1'b1 : retired_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q   <= '0;
      retired_q <= '0;
    end else if (!stall) begin
      stage_q   <= stage_d;
      retired_q <= retired_d;
    end
  end
  exe_wb_stage_flag_reg u_flag_reg (
    .clk    (clk),
    .rst    (rst),
    .en     (~stall),
    .upd    (stage_q.valid & stage_q.flags_we),
    .c_in   (stage_q.c),
    .z_in   (stage_q.z),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .c_fwd  (c_fwd),
    .z_fwd  (z_fwd)
  );
  assign wb_valid = stage_q.valid;
  assign wb_we    = stage_q.valid & stage_q.reg_we;
  assign wb_addr  = stage_q.dst;
  assign wb_data  = stage_q.data;
  assign retired  = retired_q;
endmodule

// File: tb/tb_exe_wb_stage.sv
// tb_exe_wb_stage: directed and randomized checks of exe_wb_stage against a behavioural model
module tb_exe_wb_stage;
  logic       clk = 0;
  logic       rst, in_valid, stall, flush, sel_shift;
  logic [7:0] alu_result, shift_out;
  logic       alu_c, alu_z, shift_c, shift_z;
  logic [2:0] dst_reg;
  logic       reg_we, flags_we;
  logic       wb_valid, wb_we, c_flag, z_flag, c_fwd, z_fwd;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [15:0] retired;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  exe_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .sel_shift(sel_shift), .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z),
    .shift_out(shift_out), .shift_c(shift_c), .shift_z(shift_z), .dst_reg(dst_reg),
    .reg_we(reg_we), .flags_we(flags_we), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .c_flag(c_flag), .z_flag(z_flag),
    .c_fwd(c_fwd), .z_fwd(z_fwd), .retired(retired)
  );
  always #5 clk = ~clk;
  bit       m_valid, m_c, m_z, m_rwe, m_fwe, a_c, a_z;
  bit [7:0] m_data;
  bit [2:0] m_dst;
  int       m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      {m_valid, m_c, m_z, m_rwe, m_fwe, a_c, a_z} = '0;
      m_data = 0;
      m_dst  = 0;
      m_cnt  = 0;
    end else if (!stall) begin
      if (m_valid) begin
        m_cnt = (m_cnt + 1) % 65536;
        if (m_fwe) begin
          a_c = m_c;
          a_z = m_z;
        end
      end
      m_valid = in_valid && !flush;
      m_data  = sel_shift ? shift_out : alu_result;
      m_c     = sel_shift ? shift_c : alu_c;
      m_z     = sel_shift ? shift_z : alu_z;
      m_dst   = dst_reg;
      m_rwe   = reg_we;
      m_fwe   = flags_we;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en)
      chk("model", {31'd0, wb_valid, wb_we, wb_addr, wb_data, c_flag, z_flag, c_fwd, z_fwd, retired},
          {31'd0, m_valid, m_valid && m_rwe, m_dst, m_data, a_c, a_z,
           (m_valid && m_fwe) ? m_c : a_c, (m_valid && m_fwe) ? m_z : a_z, m_cnt[15:0]});
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic op(input bit v, input bit sh, input bit [7:0] d, input bit c, input bit z,
                    input bit [2:0] dst, input bit rwe, input bit fwe);
    in_valid = v; sel_shift = sh; dst_reg = dst; reg_we = rwe; flags_we = fwe;
    if (sh) begin
      shift_out = d; shift_c = c; shift_z = z;
      alu_result = ~d; alu_c = ~c; alu_z = ~z;
    end else begin
      alu_result = d; alu_c = c; alu_z = z;
      shift_out = ~d; shift_c = ~c; shift_z = ~z;
    end
  endtask
  initial begin
    rst = 1; stall = 0; flush = 0;
    op(1, 0, 8'h33, 1, 1, 3'd1, 1, 1);
    tick();
    chk_en = 1;
    tick();
    chk("rst_valid", wb_valid, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_c", c_flag, 0);
    chk("rst_z", z_flag, 0);
    chk("rst_cnt", retired, 0);
    rst = 0;
    op(1, 1, 8'h02, 1, 0, 3'd3, 1, 1);
    tick();
    op(0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
    chk("sh_data", wb_data, 8'h02);
    chk("sh_addr", wb_addr, 3);
    chk("sh_we", wb_we, 1);
    chk("sh_cfwd", c_fwd, 1);
    chk("sh_cflag0", c_flag, 0);
    tick();
    chk("sh_cflag1", c_flag, 1);
    chk("sh_cnt", retired, 1);
    op(1, 0, 8'h00, 0, 1, 3'd2, 1, 1);
    tick();
    op(1, 0, 8'h07, 0, 0, 3'd4, 1, 0);
    chk("b2b_zfwd", z_fwd, 1);
    chk("b2b_zflag0", z_flag, 0);
    tick();
    op(0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
    chk("b2b_zflag1", z_flag, 1);
    chk("b2b_zfwd2", z_fwd, 1);
    tick();
    chk("b2b_zhold", z_flag, 1);
    chk("b2b_cnt", retired, 3);
    op(1, 0, 8'h55, 1, 0, 3'd5, 1, 1);
    tick();
    stall = 1;
    op(1, 0, 8'hAA, 0, 1, 3'd6, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", wb_data, 8'h55);
      chk("stall_cnt", retired, 3);
      chk("stall_c", c_flag, 0);
    end
    stall = 0;
    op(0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
    tick();
    chk("unstall_cnt", retired, 4);
    chk("unstall_c", c_flag, 1);
    op(1, 0, 8'h11, 0, 0, 3'd7, 1, 0);
    tick();
    flush = 1;
    tick();
    flush = 0;
    op(0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
    chk("flush_valid", wb_valid, 0);
    chk("flush_we", wb_we, 0);
    chk("flush_cnt", retired, 5);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(99) == 0;
      stall = $urandom_range(3) == 0;
      flush = $urandom_range(6) == 0;
      op($urandom_range(3) != 0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
         3'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1; stall = 0; flush = 0;
    tick();
    rst = 0;
    op(1, 0, 8'h01, 0, 0, 3'd1, 1, 0);
    repeat (65536) tick();
    chk("wrap_max", retired, 16'hFFFF);
    tick();
    chk("wrap_zero", retired, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
